dump_decoder: RTL and testbench
===============================

# dump_decoder

Receive-side counterpart of the 9-bit dump control word {dump_sel[5:0], bri_cycle, pluse_start, state_start}, sitting at the switch-driver end of the dump path. The block registers the word and detects rising edges. Each valid one-hot dump selection becomes a timed, dead-time-protected channel drive. State and pulse starts are regenerated as single-cycle strobes, and bridge cycles are counted per state.

## Interface
Parameters:
- WID_W, 8, width of dead-time and on-width configuration values and counters
- CNT_W, 12, width of bridge-cycle counter

Ports:
- clk_sys  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- code_in  in  9  control word: [8:3] one-hot dump select, [2] bri_cycle, [1] pluse_start, [0] state_start
- cfg_load  in  1  configuration write strobe
- cfg_sel  in  1  0 = dead-time register, 1 = on-width register
- cfg_data  in  WID_W  configuration value
- dump_on  out  6  one-hot channel drive, high only in ON state
- dump_ch  out  3  binary index (0..5) of the last accepted channel
- dump_busy  out  1  high in DEAD or ON state
- state_start_p  out  1  one-cycle strobe on code_in[0] rising edge
- pluse_start_p  out  1  one-cycle strobe on code_in[1] rising edge
- bri_cnt  out  CNT_W  bridge cycles since last state start
- code_err  out  1  sticky: multi-bit dump select seen at a rising edge
- overrun  out  1  sticky: dump event arrived while busy

## Operation
- Input stage: code_r <= code_in; code_d <= code_r. rise = code_r & ~code_d.
- Config registers dead_cfg (reset 4) and wid_cfg (reset 16) are written on cfg_load according to cfg_sel. They are sampled only when an event starts, so a mid-operation write affects the next event only.
- Event condition: rise[8:3] != 0.
  - Accepted only if code_r[8:3] is exactly one-hot and the FSM is in IDLE.
  - If code_r[8:3] is not one-hot at an event, code_err sets and the event is dropped.
  - If an event arrives while not in IDLE, overrun sets and the event is dropped. The non-one-hot check takes precedence.
- FSM:
  - IDLE: on an accepted event, latch the channel (dump_ch, internal one-hot).
    - dead_cfg != 0: go to DEAD with dcnt = dead_cfg.
    - dead_cfg == 0: go to ON with wcnt = max(wid_cfg, 1).
  - DEAD: dump_on = 0, dcnt decrements. When dcnt == 1, go to ON with wcnt = max(wid_cfg, 1).
  - ON: dump_on = latched one-hot, wcnt decrements. When wcnt == 1, go to IDLE.
- dump_busy = (state != IDLE), registered together with the state.
- Strobes: state_start_p = rise[0]; pluse_start_p = rise[1]; both registered and one cycle long.
- bri_cnt:
  - rise[0] clears bri_cnt, code_err and overrun.
  - Otherwise rise[2] increments bri_cnt, saturating at all-ones.
  - Simultaneous rise[0] and rise[2]: clear wins, bri_cnt = 0.
- rst_n low: state IDLE, counters 0, code_r/code_d 0, config registers to reset values.
  - Reset mid-operation drops dump_on on the next edge.
  - A code_in that is still high after reset produces a rise one cycle after code_r loads it, which is intended.

## Timing
- Reset value of every output: 0 (dump_on, dump_ch, dump_busy, strobes, bri_cnt, code_err, overrun).
- code_in is stable before edge E0 and is captured into code_r at E0. The event is evaluated from code_r/code_d and acted on at E1.
- state_start_p, pluse_start_p, bri_cnt update, code_err and overrun are all visible after E1: two-edge latency from code_in.
- dump_busy and dump_ch are valid after E1.
- dump_on rises after E1 + dead_cfg and stays high exactly max(wid_cfg, 1) cycles.
- The FSM returns to IDLE on the edge dump_on falls. An event evaluated on that same edge still sees the state as busy and flags overrun.
- A level held high produces no repeat events; only 0->1 transitions count.

## Configuration
- DUMP_DEC_BRI_CNT_EN:
  - Defined: the bridge-cycle counter is built as specified.
  - Undefined: no counter logic; bri_cnt is tied to 0. Strobes, code_err and overrun are unaffected (rise[0] still clears the flags).

## Test plan
- Reset values, then dead_cfg=4, wid_cfg=16, code_in 0 -> 0x008 (ch0): dump_busy after E1; dump_on = 6'b000001 from E1+4 for 16 cycles; dump_ch = 0.
- cfg dead=0, wid=0, code_in 0 -> 0x100 (ch5): dump_on = 6'b100000 for exactly 1 cycle starting E1; dump_ch = 5.
- code_in 0 -> 0x018 (two channels): code_err = 1, dump_busy stays 0; then pulse code_in[0]: state_start_p = 1 for one cycle, code_err cleared.
- Second event on ch2 while ch0 is in ON: overrun = 1, ch0 timing unchanged, dump_on never shows ch2; event on the last ON cycle also sets overrun.
- Toggle code_in[2] 5 times -> bri_cnt = 5; rise on bit 0 and bit 2 together -> bri_cnt = 0; 4096 toggles (CNT_W=12) -> saturates at 4095; build without DUMP_DEC_BRI_CNT_EN -> bri_cnt stays 0.
- rst_n low during ON: dump_on = 0 and dump_busy = 0 after next edge; config returns to dead 4 / width 16.

Source files
------------

// File: rtl/dump_decoder.sv
// dump_decoder: receive side of the 9-bit dump control word.
// Drives one dead-time protected channel; regenerates start strobes.
// Ports: clk_sys, rst_n (sync, active-low), code_in[8:0],
//   cfg_load/cfg_sel/cfg_data (dead-time / on-width write),
//   dump_on[5:0], dump_ch[2:0], dump_busy, state_start_p,
//   pluse_start_p, bri_cnt, code_err, overrun.
// Option: DUMP_DEC_BRI_CNT_EN builds the bridge-cycle counter.
module dump_decoder #(
  parameter int WID_W = 8,
  parameter int CNT_W = 12
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [8:0]       code_in,
  input  logic             cfg_load,
  input  logic             cfg_sel,
  input  logic [WID_W-1:0] cfg_data,
  output logic [5:0]       dump_on,
  output logic [2:0]       dump_ch,
  output logic             dump_busy,
  output logic             state_start_p,
  output logic             pluse_start_p,
  output logic [CNT_W-1:0] bri_cnt,
  output logic             code_err,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE,
    DEAD,
    ON
  } state_t;

  state_t           state, state_nx;
  logic [8:0]       code_r, code_d, rise;
  logic [5:0]       sel, oh_q, oh_nx;
  logic [WID_W-1:0] dead_cfg, wid_cfg;
  logic [WID_W-1:0] dcnt, dcnt_nx;
  logic [WID_W-1:0] wcnt, wcnt_nx;
  logic [WID_W-1:0] wid_min1;
  logic [2:0]       ch_enc;
  logic             ev, one_hot, accept;

  assign rise     = code_r & ~code_d;
  assign sel      = code_r[8:3];
  assign ev       = |rise[8:3];
  assign one_hot  = (sel != '0) &&
                    ((sel & (sel - 6'd1)) == '0);
  assign accept   = ev && one_hot && (state == IDLE);
  assign wid_min1 = (wid_cfg == '0) ? WID_W'(1) : wid_cfg;
  assign oh_nx    = accept ? sel : oh_q;

  always_comb begin
    ch_enc = '0;
    for (int i = 0; i < 6; i++)
      if (sel[i]) ch_enc = 3'(i);
  end

  // Width is captured at event start so a config write
  // during DEAD only affects the next event.
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    wcnt_nx  = wcnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          wcnt_nx = wid_min1;
          if (dead_cfg != '0) begin
            state_nx = DEAD;
            dcnt_nx  = dead_cfg;
          end else begin
            state_nx = ON;
          end
        end
      end
      DEAD: begin
        dcnt_nx = dcnt - WID_W'(1);
        if (dcnt == WID_W'(1)) state_nx = ON;
      end
      ON: begin
        wcnt_nx = wcnt - WID_W'(1);
        if (wcnt == WID_W'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      code_r    <= '0;
      code_d    <= '0;
      dead_cfg  <= WID_W'(4);
      wid_cfg   <= WID_W'(16);
      state     <= IDLE;
      dcnt      <= '0;
      wcnt      <= '0;
      oh_q      <= '0;
      dump_on   <= '0;
      dump_ch   <= '0;
      dump_busy <= 1'b0;
    end else begin
      code_r    <= code_in;
      code_d    <= code_r;
      if (cfg_load) begin
        if (cfg_sel) wid_cfg  <= cfg_data;
        else         dead_cfg <= cfg_data;
      end
      state     <= state_nx;
      dcnt      <= dcnt_nx;
      wcnt      <= wcnt_nx;
      oh_q      <= oh_nx;
      if (accept) dump_ch <= ch_enc;
      dump_on   <= (state_nx == ON) ? oh_nx : '0;
      dump_busy <= (state_nx != IDLE);
    end
  end

  // A new error on the clearing edge still latches.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_start_p <= 1'b0;
      pluse_start_p <= 1'b0;
      code_err      <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      state_start_p <= rise[0];
      pluse_start_p <= rise[1];
      if (rise[0]) begin
        code_err <= 1'b0;
        overrun  <= 1'b0;
      end
      if (ev && !one_hot)
        code_err <= 1'b1;
      else if (ev && state != IDLE)
        overrun <= 1'b1;
    end
  end

`ifdef DUMP_DEC_BRI_CNT_EN
  logic [CNT_W-1:0] bri_q;

  always_ff @(posedge clk_sys) begin
    if (!rst_n)
      bri_q <= '0;
    else if (rise[0])
      bri_q <= '0;
    else if (rise[2] && bri_q != '1)
      bri_q <= bri_q + CNT_W'(1);
  end

  assign bri_cnt = bri_q;
`else
  logic bri_unused;
  assign bri_unused = rise[2];
  assign bri_cnt    = '0;
`endif

endmodule

// File: tb/tb_dump_decoder.sv
// tb_dump_decoder: directed + random check of dump_decoder
// against a time-window reference model.
module tb_dump_decoder;

  localparam int WID_W = 8;
  localparam int CNT_W = 12;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef DUMP_DEC_BRI_CNT_EN
  localparam bit BRI_EN = 1'b1;
`else
  localparam bit BRI_EN = 1'b0;
`endif

  logic             clk_sys = 1'b0;
  logic             rst_n;
  logic [8:0]       code_in;
  logic             cfg_load;
  logic             cfg_sel;
  logic [WID_W-1:0] cfg_data;
  logic [5:0]       dump_on;
  logic [2:0]       dump_ch;
  logic             dump_busy;
  logic             state_start_p;
  logic             pluse_start_p;
  logic [CNT_W-1:0] bri_cnt;
  logic             code_err;
  logic             overrun;

  dump_decoder #(
    .WID_W(WID_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .code_in       (code_in),
    .cfg_load      (cfg_load),
    .cfg_sel       (cfg_sel),
    .cfg_data      (cfg_data),
    .dump_on       (dump_on),
    .dump_ch       (dump_ch),
    .dump_busy     (dump_busy),
    .state_start_p (state_start_p),
    .pluse_start_p (pluse_start_p),
    .bri_cnt       (bri_cnt),
    .code_err      (code_err),
    .overrun       (overrun)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: each accepted event owns an absolute
  // window of edges [on_lo, busy_end]; busy from accept edge.
  logic [8:0] m_c1, m_c2;
  int m_n = 0;
  int m_on_lo, m_end, m_acc;
  int m_dead, m_wid, m_ch, m_bri;
  bit m_err, m_ovr, m_ss, m_ps;
  bit chk_en = 1'b0;

  always @(posedge clk_sys) begin : model
    logic [8:0] r;
    logic [5:0] s;
    m_n++;
    if (!rst_n) begin
      m_c1 = '0; m_c2 = '0;
      m_end = -1; m_on_lo = 0; m_acc = 0;
      m_dead = 4; m_wid = 16;
      m_ch = 0; m_bri = 0;
      m_err = 0; m_ovr = 0;
      m_ss = 0; m_ps = 0;
      chk_en = 1'b1;
    end else begin
      r = m_c1 & ~m_c2;
      s = m_c1[8:3];
      if (r[0]) begin
        m_err = 0;
        m_ovr = 0;
      end
      if (r[8:3] != 0) begin
        if ($countones(s) != 1)
          m_err = 1;
        else if (m_n - 1 <= m_end)
          m_ovr = 1;
        else begin
          m_ch    = $clog2(s);
          m_acc   = m_n;
          m_on_lo = m_n + m_dead;
          m_end   = m_on_lo - 1 +
                    ((m_wid == 0) ? 1 : m_wid);
        end
      end
      m_ss = r[0];
      m_ps = r[1];
      if (r[0]) m_bri = 0;
      else if (r[2] && m_bri < SAT) m_bri++;
      if (cfg_load) begin
        if (cfg_sel) m_wid  = int'(cfg_data);
        else         m_dead = int'(cfg_data);
      end
      m_c2 = m_c1;
      m_c1 = code_in;
    end
  end

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("on", 32'(dump_on),
          (m_n >= m_on_lo && m_n <= m_end) ?
          (32'd1 << m_ch) : 32'd0);
      chk("busy", 32'(dump_busy), 32'(m_n <= m_end));
      chk("ch", 32'(dump_ch), 32'(m_ch));
      chk("ss", 32'(state_start_p), 32'(m_ss));
      chk("ps", 32'(pluse_start_p), 32'(m_ps));
      chk("bri", 32'(bri_cnt),
          BRI_EN ? 32'(m_bri) : 32'd0);
      chk("err", 32'(code_err), 32'(m_err));
      chk("ovr", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk_sys);
  endtask

  task automatic put(input logic [8:0] v);
    @(negedge clk_sys);
    code_in = v;
  endtask

  task automatic cfg(input bit s, input int v);
    @(negedge clk_sys);
    cfg_load = 1'b1;
    cfg_sel  = s;
    cfg_data = WID_W'(v);
    @(negedge clk_sys);
    cfg_load = 1'b0;
  endtask

  task automatic on_len(input string tag,
                        input int lim,
                        input int want);
    int c = 0;
    repeat (lim) begin
      @(negedge clk_sys);
      if (dump_on != '0) c++;
    end
    chk(tag, 32'(c), 32'(want));
  endtask

  initial begin
    logic [8:0] v;
    rst_n    = 1'b0;
    code_in  = '0;
    cfg_load = 1'b0;
    cfg_sel  = 1'b0;
    cfg_data = '0;
    cyc(3);
    chk("rst_on", 32'(dump_on), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_bri", 32'(bri_cnt), 32'd0);
    rst_n = 1'b1;
    cyc(2);

    // ch0, dead 4, width 16
    put(9'h008);
    cyc(2);
    chk("t1_busy", 32'(dump_busy), 32'd1);
    chk("t1_ch", 32'(dump_ch), 32'd0);
    cyc(3);
    chk("t1_pre", 32'(dump_on), 32'd0);
    cyc(1);
    chk("t1_on", 32'(dump_on), 32'h01);
    on_len("t1_len", 30, 15);
    put(9'h000);
    cyc(3);

    // ch5, dead 0, width 0 -> one cycle
    cfg(1'b0, 0);
    cfg(1'b1, 0);
    put(9'h100);
    cyc(2);
    chk("t2_on", 32'(dump_on), 32'h20);
    chk("t2_ch", 32'(dump_ch), 32'd5);
    cyc(1);
    chk("t2_off", 32'(dump_on), 32'd0);
    put(9'h000);
    cyc(3);

    // two-channel select, then state start clears
    put(9'h018);
    cyc(2);
    chk("t3_err", 32'(code_err), 32'd1);
    chk("t3_busy", 32'(dump_busy), 32'd0);
    put(9'h000);
    cyc(2);
    put(9'h001);
    put(9'h000);
    cyc(1);
    chk("t3_ss", 32'(state_start_p), 32'd1);
    chk("t3_clr", 32'(code_err), 32'd0);
    cyc(1);
    chk("t3_ss1", 32'(state_start_p), 32'd0);

    // overrun sweep: ON covers edges n+2..n+7
    cfg(1'b0, 2);
    cfg(1'b1, 6);
    for (int k = 1; k <= 12; k++) begin
      put(9'h001);
      put(9'h000);
      cyc(2);
      put(9'h008);
      for (int j = 1; j < k; j++) put(9'h000);
      put(9'h020);
      put(9'h000);
      cyc(15);
      chk($sformatf("t4_ovr%0d", k),
          32'(overrun), 32'(k <= 8));
    end

    // bridge cycle counter
    put(9'h001);
    put(9'h000);
    for (int k = 0; k < 5; k++) begin
      put(9'h004);
      put(9'h000);
    end
    cyc(2);
    chk("t5_bri5", 32'(bri_cnt), BRI_EN ? 32'd5 : 32'd0);
    put(9'h005);
    put(9'h000);
    cyc(2);
    chk("t5_clr", 32'(bri_cnt), 32'd0);
    for (int k = 0; k < 4096; k++) begin
      put(9'h004);
      put(9'h000);
    end
    cyc(2);
    chk("t5_sat", 32'(bri_cnt),
        BRI_EN ? 32'(SAT) : 32'd0);

    // reset during ON; held code re-fires with defaults
    cfg(1'b0, 1);
    cfg(1'b1, 20);
    put(9'h040);
    cyc(6);
    rst_n = 1'b0;
    cyc(1);
    chk("t6_on", 32'(dump_on), 32'd0);
    chk("t6_busy", 32'(dump_busy), 32'd0);
    rst_n = 1'b1;
    on_len("t6_len", 40, 16);
    put(9'h000);
    cyc(3);

    // random traffic: one field group changes per edge
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk_sys);
      cfg_load = ($urandom_range(0, 7) == 0);
      cfg_sel  = 1'($urandom_range(0, 1));
      cfg_data = cfg_sel ? WID_W'($urandom_range(0, 6))
                         : WID_W'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) begin
        v = code_in;
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 3))
            0: v[8:3] = '0;
            3: v[8:3] = 6'($urandom);
            default:
              v[8:3] = 6'b1 << $urandom_range(0, 5);
          endcase
        end else begin
          v[2:0] = 3'($urandom);
        end
        code_in = v;
      end
    end
    @(negedge clk_sys);
    cfg_load = 1'b0;
    cyc(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
